// File: rtl/seq_div_if.sv
// Handshake and operand bundle between a requester and the sequential divider.
interface seq_div_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            kill_i;
  logic            ready_o;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, op_i, a_i, b_i, kill_i,
    input  ready_o, busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, kill_i,
    output ready_o, busy_o, done_o, result_o
  );
endinterface

// File: rtl/seq_div_unit.sv
// Sequential restoring divider for RISC-V DIV/DIVU/REM/REMU.
// Retires STEP quotient bits per cycle; special cases (divide by zero,
// signed overflow) complete one cycle after accept.
//
// state  | meaning
// IDLE   | waiting for start, ready_o high
// RUN    | shift-subtract iterations, counter counts down to zero
// FIX    | select quotient/remainder and apply result sign
// DONE   | one-cycle done_o pulse, then back to IDLE
module seq_div_unit #(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input logic     clk_i,
  input logic     reset_i,
  seq_div_if.slave dif
);

  localparam int ITER = XLEN / STEP;
  localparam int CW   = $clog2(ITER + 1);
  localparam int WW   = XLEN + STEP;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   rem_q, rem_d;
  logic [WW-1:0]   dvs_q, dvs_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [1:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic            done_q, done_d;
  logic            ready_q;
  logic            busy_q;

  logic            is_signed;
  logic            a_neg;
  logic            b_neg;
  logic            b_zero;
  logic            ovf;
  logic            res_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;

  logic [WW-1:0]   step_rem;
  logic [WW-1:0]   trial;
  logic [XLEN-1:0] step_quo;
  logic [XLEN-1:0] fix_val;

  // Decode the operands presented at the accept edge: magnitudes, result sign, special cases.
  // Negating 100..0 yields 100..0, which is then simply used as an unsigned magnitude.
  always_comb begin
    is_signed = ~dif.op_i[0];
    a_neg     = is_signed & dif.a_i[XLEN-1];
    b_neg     = is_signed & dif.b_i[XLEN-1];
    a_mag     = a_neg ? -dif.a_i : dif.a_i;
    b_mag     = b_neg ? -dif.b_i : dif.b_i;
    b_zero    = (dif.b_i == '0);
    ovf       = is_signed & (dif.a_i == {1'b1, {(XLEN-1){1'b0}}}) & (&dif.b_i);
    res_neg   = dif.op_i[1] ? a_neg : (a_neg ^ b_neg);
  end

  // STEP restoring shift-subtract steps, MSB of the dividend first.
  always_comb begin
    step_rem = rem_q;
    step_quo = quo_q;
    trial    = '0;
    for (int i = 0; i < STEP; i++) begin
      trial    = {step_rem[WW-2:0], step_quo[XLEN-1]};
      step_quo = {step_quo[XLEN-2:0], 1'b0};
      if (trial >= dvs_q) begin
        step_rem    = trial - dvs_q;
        step_quo[0] = 1'b1;
      end else begin
        step_rem = trial;
      end
    end
  end

  // Remainder bits above XLEN stay zero since the remainder is always below the divisor.
  always_comb begin
    fix_val = op_q[1] ? rem_q[XLEN-1:0] : quo_q;
  end

  // Next-state and next-datapath logic; kill overrides everything except reset.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    quo_d    = quo_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (dif.start_i && !dif.kill_i) begin
          op_d  = dif.op_i;
          neg_d = res_neg;
          if (b_zero) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = dif.op_i[1] ? dif.a_i : '1;
          end else if (ovf) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = dif.op_i[1] ? '0 : dif.a_i;
          end else begin
            state_d = S_RUN;
            cnt_d   = CW'(ITER);
            rem_d   = '0;
            quo_d   = a_mag;
            dvs_d   = {{STEP{1'b0}}, b_mag};
          end
        end
      end
      S_RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d  = S_DONE;
        done_d   = 1'b1;
        result_d = neg_q ? -fix_val : fix_val;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (dif.kill_i) begin
      state_d  = S_IDLE;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  // State and datapath registers; status outputs are registered from the next state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      quo_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      quo_q    <= quo_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      done_q   <= done_d;
      ready_q  <= (state_d == S_IDLE);
      busy_q   <= (state_d != S_IDLE);
    end
  end

  assign dif.ready_o  = ready_q;
  assign dif.busy_o   = busy_q;
  assign dif.done_o   = done_q;
  assign dif.result_o = result_q;

endmodule

// File: tb/tb_seq_div_unit.sv
// Bench for seq_div_unit: three instances (32/1, 32/4, 64/2) driven in lockstep
// and compared against a RISC-V M-extension arithmetic model.
module tb_seq_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        kill;
  logic [1:0]  op;
  logic [63:0] a;
  logic [63:0] b;

  always #5 clk = ~clk;

  seq_div_if #(.XLEN(32)) if0 ();
  seq_div_if #(.XLEN(32)) if1 ();
  seq_div_if #(.XLEN(64)) if2 ();

  assign if0.start_i = start;
  assign if0.op_i    = op;
  assign if0.a_i     = a[31:0];
  assign if0.b_i     = b[31:0];
  assign if0.kill_i  = kill;
  assign if1.start_i = start;
  assign if1.op_i    = op;
  assign if1.a_i     = a[31:0];
  assign if1.b_i     = b[31:0];
  assign if1.kill_i  = kill;
  assign if2.start_i = start;
  assign if2.op_i    = op;
  assign if2.a_i     = a;
  assign if2.b_i     = b;
  assign if2.kill_i  = kill;

  seq_div_unit #(.XLEN(32), .STEP(1)) u0 (.clk_i(clk), .reset_i(rst), .dif(if0));
  seq_div_unit #(.XLEN(32), .STEP(4)) u1 (.clk_i(clk), .reset_i(rst), .dif(if1));
  seq_div_unit #(.XLEN(64), .STEP(2)) u2 (.clk_i(clk), .reset_i(rst), .dif(if2));

  logic        rdy [3];
  logic        bsy [3];
  logic        dn  [3];
  logic [63:0] res [3];

  assign rdy[0] = if0.ready_o;
  assign rdy[1] = if1.ready_o;
  assign rdy[2] = if2.ready_o;
  assign bsy[0] = if0.busy_o;
  assign bsy[1] = if1.busy_o;
  assign bsy[2] = if2.busy_o;
  assign dn[0]  = if0.done_o;
  assign dn[1]  = if1.done_o;
  assign dn[2]  = if2.done_o;
  assign res[0] = {32'h0, if0.result_o};
  assign res[1] = {32'h0, if1.result_o};
  assign res[2] = if2.result_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          xl [3]  = '{32, 32, 64};
  int          st [3]  = '{1, 4, 2};
  logic [63:0] exp_res [3];

  task automatic check(input string tag, input int idx, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s dut%0d: got %0h expected %0h", tag, idx, obs, expv);
    end
  endtask

  function automatic logic [63:0] mask_of(input int xlen);
    return (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic bit is_special(input int xlen, input logic [1:0] f, input logic [63:0] x, input logic [63:0] y);
    logic [63:0] m;
    m = mask_of(xlen);
    if ((y & m) == 64'h0) return 1'b1;
    if (!f[0] && ((x & m) == (64'h1 << (xlen - 1))) && ((y & m) == m)) return 1'b1;
    return 1'b0;
  endfunction

  // RISC-V M semantics: truncating division, remainder takes the dividend's sign.
  function automatic logic [63:0] ref_model(input int xlen, input logic [1:0] f, input logic [63:0] x, input logic [63:0] y);
    logic [63:0]        m, ux, uy, r;
    logic signed [31:0] t;
    longint             sx, sy, q;
    bit                 ovf;
    m  = mask_of(xlen);
    ux = x & m;
    uy = y & m;
    if (xlen == 32) begin
      t  = ux[31:0];
      sx = t;
      t  = uy[31:0];
      sy = t;
    end else begin
      sx = ux;
      sy = uy;
    end
    ovf = (ux == (64'h1 << (xlen - 1))) && (uy == m);
    r   = 64'h0;
    case (f)
      2'b00: begin
        if (uy == 0) r = '1;
        else if (ovf) r = ux;
        else begin q = sx / sy; r = q; end
      end
      2'b01: begin
        if (uy == 0) r = '1;
        else r = ux / uy;
      end
      2'b10: begin
        if (uy == 0) r = ux;
        else if (ovf) r = 64'h0;
        else begin q = sx % sy; r = q; end
      end
      default: begin
        if (uy == 0) r = ux;
        else r = ux % uy;
      end
    endcase
    return r & m;
  endfunction

  // One operation on all three units. stop>0 asserts kill (or reset) during that cycle;
  // cycle numbering: the accept edge is cycle 0, samples are taken mid-cycle.
  task automatic run_op(input logic [1:0] f, input logic [63:0] x, input logic [63:0] y,
                        input int stop, input bit use_reset, input int ncyc);
    int          lat  [3];
    int          dcnt [3];
    int          dcyc [3];
    logic [63:0] dres [3];
    logic [63:0] rv   [3];
    int          stop_eff;
    bit          inject;
    stop_eff = (stop == 0) ? 100000 : stop;
    inject   = (stop == 0);
    for (int i = 0; i < 3; i++) begin
      rv[i]   = ref_model(xl[i], f, x, y);
      lat[i]  = is_special(xl[i], f, x, y) ? 1 : (xl[i] / st[i] + 2);
      dcnt[i] = 0;
      dcyc[i] = -1;
      dres[i] = 64'h0;
      if (lat[i] <= 3) inject = 1'b0;
    end
    start = 1'b1;
    op    = f;
    a     = x;
    b     = y;
    kill  = 1'b0;
    rst   = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (dn[i] === 1'b1) begin
          dcnt[i]++;
          dcyc[i] = c;
          dres[i] = res[i];
        end
        if (c == 1) begin
          check("busy_c1", i, {63'h0, bsy[i]}, 64'h1);
          check("ready_c1", i, {63'h0, rdy[i]}, 64'h0);
        end
        if (c == stop + 1 && stop != 0) begin
          check("ready_after_stop", i, {63'h0, rdy[i]}, 64'h1);
          check("busy_after_stop", i, {63'h0, bsy[i]}, 64'h0);
          check("done_after_stop", i, {63'h0, dn[i]}, 64'h0);
          if (use_reset) check("result_after_reset", i, res[i], 64'h0);
        end
      end
      start = 1'b0;
      kill  = 1'b0;
      rst   = 1'b0;
      op    = 2'($urandom_range(0, 3));
      a     = {$urandom, $urandom};
      b     = {$urandom, $urandom};
      if (inject && (c == 3 || c == 10)) start = 1'b1;
      if (c == stop) begin
        start = 1'b1;
        kill  = 1'b1;
        rst   = use_reset;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (lat[i] <= stop_eff) begin
        check("done_count", i, 64'(dcnt[i]), 64'h1);
        check("latency", i, 64'(dcyc[i]), 64'(lat[i]));
        check("result", i, dres[i], rv[i]);
        exp_res[i] = rv[i];
      end else begin
        check("done_count", i, 64'(dcnt[i]), 64'h0);
      end
      if (stop != 0 && use_reset) exp_res[i] = 64'h0;
      check("result_hold", i, res[i], exp_res[i]);
      check("ready_end", i, {63'h0, rdy[i]}, 64'h1);
    end
  endtask

  initial begin
    logic [1:0]  rf;
    logic [63:0] ra, rb;
    int          mode, sel, stp;
    rst   = 1'b1;
    start = 1'b0;
    kill  = 1'b0;
    op    = 2'b00;
    a     = 64'h0;
    b     = 64'h0;
    for (int i = 0; i < 3; i++) exp_res[i] = 64'h0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_ready", i, {63'h0, rdy[i]}, 64'h1);
      check("reset_busy", i, {63'h0, bsy[i]}, 64'h0);
      check("reset_done", i, {63'h0, dn[i]}, 64'h0);
      check("reset_result", i, res[i], 64'h0);
    end
    rst = 1'b0;

    // Directed: signed division/remainder, start on the first edge after reset
    run_op(2'b00, 64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 0, 1'b0, 45);
    run_op(2'b10, 64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 0, 1'b0, 45);
    // Divide by zero
    run_op(2'b01, 64'h5, 64'h0, 0, 1'b0, 45);
    run_op(2'b11, 64'h5, 64'h0, 0, 1'b0, 45);
    // 32-bit signed overflow (64-bit unit sees a normal positive dividend)
    run_op(2'b00, 64'h8000_0000, 64'hFFFF_FFFF, 0, 1'b0, 45);
    run_op(2'b10, 64'h8000_0000, 64'hFFFF_FFFF, 0, 1'b0, 45);
    // 64-bit signed overflow (32-bit units see zero dividend, normal path)
    run_op(2'b00, 64'h8000_0000_0000_0000, '1, 0, 1'b0, 45);
    run_op(2'b10, 64'h8000_0000_0000_0000, '1, 0, 1'b0, 45);
    // Kill at cycle 10, then an immediate new start at cycle 11
    run_op(2'b01, 64'd100, 64'd7, 10, 1'b0, 11);
    run_op(2'b01, 64'd100, 64'd7, 0, 1'b0, 45);
    run_op(2'b11, 64'd100, 64'd7, 0, 1'b0, 45);
    // Reset at cycle 5, then start on the first edge after reset
    run_op(2'b01, 64'd100, 64'd7, 5, 1'b1, 6);
    run_op(2'b00, 64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 0, 1'b0, 45);
    // Kill and start together while idle: start must not be accepted
    run_op(2'b01, 64'h5, 64'h0, 3, 1'b0, 4);

    // Randomized operations with kill/reset collisions
    for (int n = 0; n < 60; n++) begin
      rf   = 2'($urandom_range(0, 3));
      mode = $urandom_range(0, 9);
      ra   = {$urandom, $urandom};
      rb   = {$urandom, $urandom} >> $urandom_range(0, 63);
      case (mode)
        0: rb = 64'h0;
        1: begin ra = 64'hFFFF_FFFF_8000_0000; rb = '1; end
        2: begin ra = 64'h8000_0000_0000_0000; rb = '1; end
        3: ra = 64'h0;
        4: rb = ($urandom_range(0, 1) == 1) ? -64'($urandom_range(1, 15)) : 64'($urandom_range(1, 15));
        default: ;
      endcase
      sel = $urandom_range(0, 5);
      stp = $urandom_range(1, 36);
      if (sel == 0)      run_op(rf, ra, rb, stp, 1'b0, stp + 1);
      else if (sel == 1) run_op(rf, ra, rb, stp, 1'b1, stp + 1);
      else               run_op(rf, ra, rb, 0, 1'b0, 45);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_div_unit.md
SEQ_DIV_UNIT -- requirements
Module: seq_div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; legal values 32 or 64.
REQ-002 SHALL have parameter STEP, default 1, quotient bits retired per cycle; legal values 1, 2, 4; XLEN % STEP == 0.
REQ-003 SHALL have port clk_i  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start_i  input  1  request a new operation; accepted only when ready_o=1.
REQ-006 SHALL have port op_i  input  2  funct3[1:0] encoding: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 SHALL have port a_i  input  XLEN  dividend, sampled on the accept edge only.
REQ-008 SHALL have port b_i  input  XLEN  divisor, sampled on the accept edge only.
REQ-009 SHALL have port kill_i  input  1  abort the in-flight operation (pipeline flush).
REQ-010 SHALL have port ready_o  output  1  high in IDLE only.
REQ-011 SHALL have port busy_o  output  1  high in any state other than IDLE.
REQ-012 SHALL have port done_o  output  1  one-cycle pulse; result_o is valid in that cycle.
REQ-013 SHALL have port result_o  output  XLEN  quotient or remainder; holds its value until the next accepted start.

Function
REQ-014 SHALL implement states IDLE, RUN, FIX and DONE; all outputs are registered.
REQ-015 Accept: on an edge with state IDLE & start_i & !kill_i, SHALL latch op, the operand magnitudes (negated if the op is signed and the operand MSB is 1) and the result sign; call this edge cycle 0.
REQ-016 Result sign SHALL be: DIV a[MSB]^b[MSB]; REM a[MSB]; unsigned ops positive.
REQ-017 Special case b==0, decided at accept: next state DONE; result = all ones for DIV/DIVU, a_i for REM/REMU.
REQ-018 Special case signed overflow (DIV/REM with a=100..0 and b=all ones), decided at accept: next state DONE; DIV result = a_i, REM result = 0.
REQ-019 Special cases SHALL assert done_o in cycle 1.
REQ-020 Normal case: SHALL enter RUN with an iteration counter = XLEN/STEP, remainder = 0 and quotient shift register = dividend magnitude.
REQ-021 Each RUN cycle SHALL perform STEP restoring shift-subtract steps, MSB first, and decrement the counter.
REQ-022 SHALL go from RUN to FIX when the counter reaches 0.
REQ-023 FIX SHALL select the quotient (DIV/DIVU) or remainder (REM/REMU), apply two's-complement negation if the result sign is set, load result_o and go to DONE.
REQ-024 Normal-case latency: done_o SHALL assert in cycle XLEN/STEP + 2 (34 for XLEN=32, STEP=1).
REQ-025 DONE SHALL last one cycle, assert done_o, then return to IDLE; ready_o is low in DONE, so start_i in DONE is ignored.
REQ-026 start_i while busy_o=1 SHALL be ignored, with no effect on the operation in progress.
REQ-027 kill_i SHALL move any state to IDLE on the next edge, suppress done_o and leave result_o unchanged.
REQ-028 kill_i SHALL take priority over start_i on the same edge; that start is not accepted.
REQ-029 A zero dividend SHALL follow the normal path and produce result 0, with no early-out.
REQ-030 All internal arithmetic SHALL be XLEN+STEP bits wide so that no carry is lost; magnitude negation of 100..0 yields 100..0 and is treated as unsigned.

Reset
REQ-031 reset_i high on an edge SHALL force state IDLE, ready_o=1, busy_o=0, done_o=0, result_o=0, counter=0, in any state including mid-RUN.
REQ-032 reset_i SHALL take priority over kill_i and start_i.
REQ-033 After reset deasserts, start_i SHALL be accepted on the first edge.

Verification
REQ-034 XLEN=32, STEP=1, DIV a=0xFFFFFFF9 (-7), b=2 -> result 0xFFFFFFFD, done_o at cycle 34 only; REM with the same operands -> 0xFFFFFFFF.
REQ-035 DIVU a=5, b=0 -> 0xFFFFFFFF at cycle 1; REMU a=5, b=0 -> 0x00000005 at cycle 1.
REQ-036 DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 at cycle 1; REM with the same operands -> 0x00000000.
REQ-037 Start DIVU 100/7, kill_i at cycle 10 -> no done_o, ready_o=1 at cycle 11, result_o unchanged; a new start is accepted at cycle 11 and completes correctly.
REQ-038 STEP=4: DIVU 100/7 -> 14 with done_o at cycle 10; REMU 100/7 -> 2. Also reset_i at cycle 5 of an operation -> all outputs take reset values next cycle and done_o never pulses.
REQ-039 Random signed/unsigned operands for every legal XLEN/STEP pair SHALL match a RISC-V M-extension reference model, including all start/kill/reset collisions.
